msrv32_wb_pipe_unit: RTL and testbench
======================================

MSRV32_WB_PIPE_UNIT -- requirements
Module: msrv32_wb_pipe_unit

Interface
REQ-001 Parameter XLEN, default 32: data width of every write-back source and output.
REQ-002 Parameter NUM_SRC, default 8: number of write-back sources; SEL_W = clog2(NUM_SRC).
REQ-003 Parameter RADDR_W, default 5: register-file address width.
REQ-004 ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous assertion, active-low.
REQ-006 in_valid_in  input  1  upstream holds a valid write-back request.
REQ-007 in_ready_out  output  1  block can accept a request this cycle.
REQ-008 wb_mux_sel_in  input  SEL_W  source select; index k selects src_data_in slice [k*XLEN +: XLEN].
REQ-009 src_data_in  input  NUM_SRC*XLEN  flattened source bus; slot 0 ALU, 1 LU, 2 IMM, 3 IADDER, 4 CSR, 5 PC+4, rest spare.
REQ-010 lu_valid_in  input  1  load-unit data in slot 1 is valid.
REQ-011 rd_addr_in  input  RADDR_W  destination register.
REQ-012 rf_wr_en_in  input  1  request writes the register file.
REQ-013 alu_src_in  input  1  1 selects rs_2_in, 0 selects imm_in, for alu_2nd_src_out.
REQ-014 rs_2_in, imm_in  input  XLEN each  ALU second-operand candidates.
REQ-015 alu_2nd_src_out  output  XLEN  combinational ALU second operand.
REQ-016 flush_in  input  1  discard all buffered requests.
REQ-017 out_valid_out  output  1  head entry valid.
REQ-018 out_ready_in  input  1  register file consumes head entry.
REQ-019 wb_data_out  output  XLEN; rd_addr_out  output  RADDR_W; rf_wr_en_out  output  1  head entry fields.
REQ-020 fwd_rs_addr_in  input  RADDR_W  operand address queried for forwarding.
REQ-021 fwd_hit_out  output  1; fwd_data_out  output  XLEN  forwarding result.
REQ-022 sel_err_out  output  1  sticky: out-of-range select was accepted.

Function
REQ-023 Block SHALL hold a 2-entry FIFO (count 0..2) of {data, rd_addr, wr_en}; in_ready_out SHALL be 1 iff count<2 and flush_in=0.
REQ-024 Push SHALL occur iff in_valid_in & in_ready_out & (wb_mux_sel_in!=1 | lu_valid_in); a LU request without lu_valid_in SHALL wait, not be dropped.
REQ-025 Pushed data SHALL be the selected slot captured that cycle; selects >=NUM_SRC or >5 SHALL capture slot 0 and set sel_err_out.
REQ-026 Pushed wr_en SHALL be rf_wr_en_in & (rd_addr_in!=0).
REQ-027 Pop SHALL occur iff out_valid_out & out_ready_in; out_valid_out SHALL be 1 iff count>0; outputs SHALL show oldest entry.
REQ-028 Push and pop in one cycle SHALL keep count unchanged and preserve order; latency input-to-output is exactly 1 cycle when empty.
REQ-029 flush_in=1 SHALL set count to 0 next cycle and block any same-cycle push; sel_err_out unaffected.
REQ-030 fwd_hit_out SHALL be 1 iff fwd_rs_addr_in!=0 and some valid entry has wr_en=1 and matching rd_addr; fwd_data_out SHALL be the youngest such entry's data, else 0.
REQ-031 alu_2nd_src_out SHALL be purely combinational, independent of FIFO state.

Reset
REQ-032 Reset low SHALL immediately force count=0, out_valid_out=0, wb_data_out=0, rd_addr_out=0, rf_wr_en_out=0, sel_err_out=0, fwd_hit_out=0, in_ready_out=0 while asserted; in_ready_out=1 first cycle after release.
REQ-033 Reset mid-transfer SHALL discard all entries; no partial entry SHALL survive.

Structure
REQ-034 WB_ALU..WB_PC_PLUS select encodings (0..5) and FIFO depth SHALL live in shared package msrv32_pkg.
REQ-035 FIFO SHALL be sub-module msrv32_wb_skid_buf (parametrised width, depth 2); mux, forwarding, error logic stay in top.

Verification
REQ-036 Empty, push sel=0 slot0=0x11, rd=5, out_ready=1 -> next cycle out_valid=1, wb_data=0x11, rd=5, wr_en=1.
REQ-037 out_ready=0, push sel=4 (0xC5) then sel=5 (0x104) -> in_ready=0 after 2nd push; release -> 0xC5 then 0x104 in order.
REQ-038 sel=1, lu_valid=0 for 3 cycles then 1 with slot1=0xABCD -> no push until lu_valid, then wb_data=0xABCD.
REQ-039 Two entries rd=7 (0x1 older, 0x2 younger), fwd_rs_addr=7 -> fwd_hit=1, fwd_data=0x2; rd=0 entry -> wr_en=0, no hit.
REQ-040 Count=2, flush_in and in_valid both 1 -> next cycle count=0, out_valid=0; sel=7 accepted -> data=slot0, sel_err_out=1 until reset.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared write-back definitions: source select encodings and buffer depth.
package msrv32_pkg;

  typedef enum logic [2:0] {
    WB_ALU     = 3'd0,
    WB_LU      = 3'd1,
    WB_IMM     = 3'd2,
    WB_IADDER  = 3'd3,
    WB_CSR     = 3'd4,
    WB_PC_PLUS = 3'd5
  } wb_sel_e;

  localparam int          WB_FIFO_DEPTH = 2;
  localparam int unsigned WB_LAST_SRC   = 32'(WB_PC_PLUS);
  localparam int unsigned WB_LU_SEL     = 32'(WB_LU);

endpackage

// File: rtl/msrv32_wb_skid_buf.sv
// Two-entry in-order buffer; exposes the head and the entry behind it so the
// parent can search both for operand forwarding.
module msrv32_wb_skid_buf
  import msrv32_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [W-1:0] next_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [WB_FIFO_DEPTH];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  assign push_ok = push_i & ~flush_i & (count_q != 2'd2);
  assign pop_ok  = pop_i  & ~flush_i & (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= ~wr_ptr_q;
        if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Storage carries no reset: entries are only observed through count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[~rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/msrv32_wb_pipe_unit.sv
// Write-back stage: source mux, 2-deep request buffer toward the register
// file, forwarding lookup over buffered results, and sticky select error.
module msrv32_wb_pipe_unit
  import msrv32_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NUM_SRC = 8,
  parameter  int RADDR_W = 5,
  localparam int SEL_W   = $clog2(NUM_SRC),
  localparam int EW      = XLEN + RADDR_W + 1
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_n_in,
  input  logic                    in_valid_in,
  output logic                    in_ready_out,
  input  logic [SEL_W-1:0]        wb_mux_sel_in,
  input  logic [NUM_SRC*XLEN-1:0] src_data_in,
  input  logic                    lu_valid_in,
  input  logic [RADDR_W-1:0]      rd_addr_in,
  input  logic                    rf_wr_en_in,
  input  logic                    alu_src_in,
  input  logic [XLEN-1:0]         rs_2_in,
  input  logic [XLEN-1:0]         imm_in,
  output logic [XLEN-1:0]         alu_2nd_src_out,
  input  logic                    flush_in,
  output logic                    out_valid_out,
  input  logic                    out_ready_in,
  output logic [XLEN-1:0]         wb_data_out,
  output logic [RADDR_W-1:0]      rd_addr_out,
  output logic                    rf_wr_en_out,
  input  logic [RADDR_W-1:0]      fwd_rs_addr_in,
  output logic                    fwd_hit_out,
  output logic [XLEN-1:0]         fwd_data_out,
  output logic                    sel_err_out
);

  logic [XLEN-1:0] push_data;
  logic [EW-1:0]   head, next;
  logic [1:0]      count;
  logic            sel_ok, lu_ok, push, pop, sel_err_q;
  int unsigned     sel_u, src_idx;

  assign alu_2nd_src_out = alu_src_in ? rs_2_in : imm_in;

  always_comb begin
    sel_u     = 32'(wb_mux_sel_in);
    sel_ok    = (sel_u < $unsigned(NUM_SRC)) && (sel_u <= WB_LAST_SRC);
    src_idx   = sel_ok ? sel_u : 32'd0;
    push_data = src_data_in[src_idx*XLEN +: XLEN];
    lu_ok     = (sel_u != WB_LU_SEL) | lu_valid_in;
  end

  // Ready drops during reset so nothing upstream sees a phantom acceptance.
  assign in_ready_out  = ms_riscv32_mp_rst_n_in & (count != 2'd2) & ~flush_in;
  assign push          = in_valid_in & in_ready_out & lu_ok;
  assign out_valid_out = (count != 2'd0);
  assign pop           = out_valid_out & out_ready_in;

  msrv32_wb_skid_buf #(.W(EW)) u_buf (
    .clk_i   (ms_riscv32_mp_clk_in),
    .rst_ni  (ms_riscv32_mp_rst_n_in),
    .flush_i (flush_in),
    .push_i  (push),
    .data_i  ({push_data, rd_addr_in, rf_wr_en_in & (rd_addr_in != '0)}),
    .pop_i   (pop),
    .head_o  (head),
    .next_o  (next),
    .count_o (count)
  );

  assign wb_data_out  = out_valid_out ? head[EW-1 -: XLEN]   : '0;
  assign rd_addr_out  = out_valid_out ? head[RADDR_W:1]      : '0;
  assign rf_wr_en_out = out_valid_out & head[0];

  // The entry behind the head is the younger one and wins on a double hit.
  always_comb begin
    fwd_hit_out  = 1'b0;
    fwd_data_out = '0;
    if (fwd_rs_addr_in != '0) begin
      if (count == 2'd2 && next[0] && next[RADDR_W:1] == fwd_rs_addr_in) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = next[EW-1 -: XLEN];
      end else if (count != 2'd0 && head[0] && head[RADDR_W:1] == fwd_rs_addr_in) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = head[EW-1 -: XLEN];
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      sel_err_q <= 1'b0;
    end else if (push && !sel_ok) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err_out = sel_err_q;

endmodule

// File: tb/tb_msrv32_wb_pipe_unit.sv
// Scoreboard bench for the write-back pipe unit: the driver queues expected
// entries as requests are accepted, the monitor checks outputs every cycle.
module tb_msrv32_wb_pipe_unit;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, lu_valid = 1'b0, rf_we = 1'b0, alu_src = 1'b0;
  logic        flush = 1'b0, out_ready = 1'b0;
  logic [2:0]  sel = '0;
  logic [4:0]  rd = '0, fwd_a = '0;
  logic [31:0] rs2 = '0, imm = '0;
  logic [31:0] slot [8];
  logic [255:0] src_bus;

  logic        in_ready, out_valid, rf_we_o, fwd_hit, sel_err;
  logic [31:0] alu2, wb_data, fwd_data;
  logic [4:0]  rd_o;

  ent_t sb[$];
  logic err_m = 1'b0;
  int   n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    src_bus = '0;
    for (int i = 0; i < 8; i++) src_bus[i*32 +: 32] = slot[i];
  end

  msrv32_wb_pipe_unit dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .in_valid_in            (in_valid),
    .in_ready_out           (in_ready),
    .wb_mux_sel_in          (sel),
    .src_data_in            (src_bus),
    .lu_valid_in            (lu_valid),
    .rd_addr_in             (rd),
    .rf_wr_en_in            (rf_we),
    .alu_src_in             (alu_src),
    .rs_2_in                (rs2),
    .imm_in                 (imm),
    .alu_2nd_src_out        (alu2),
    .flush_in               (flush),
    .out_valid_out          (out_valid),
    .out_ready_in           (out_ready),
    .wb_data_out            (wb_data),
    .rd_addr_out            (rd_o),
    .rf_wr_en_out           (rf_we_o),
    .fwd_rs_addr_in         (fwd_a),
    .fwd_hit_out            (fwd_hit),
    .fwd_data_out           (fwd_data),
    .sel_err_out            (sel_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: checks every cycle, retires the head when the sink takes it.
  initial begin
    logic        hit;
    logic [31:0] fd;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_rd_addr", rd_o, 0);
        chk("rst_wr_en", rf_we_o, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
      end else begin
        chk("alu_2nd_src", alu2, alu_src ? rs2 : imm);
        chk("in_ready", in_ready, (sb.size() < 2) && !flush);
        chk("out_valid", out_valid, sb.size() > 0);
        chk("sel_err", sel_err, err_m);
        hit = 1'b0;
        fd  = '0;
        if (fwd_a != 0) begin
          for (int i = sb.size() - 1; i >= 0; i--) begin
            if (!hit && sb[i].we && sb[i].rd == fwd_a) begin
              hit = 1'b1;
              fd  = sb[i].data;
            end
          end
        end
        chk("fwd_hit", fwd_hit, hit);
        chk("fwd_data", fwd_data, fd);
        if (sb.size() > 0) begin
          chk("wb_data", wb_data, sb[0].data);
          chk("rd_addr", rd_o, sb[0].rd);
          chk("wr_en", rf_we_o, sb[0].we);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Driver: applies one cycle of stimulus and queues the expected entry.
  task automatic step(input bit v, input int s, input int r, input bit w,
                      input bit ory, input bit fl, input bit luv, input logic [31:0] sd);
    ent_t e;
    bit   do_push;
    int   eff;
    @(negedge clk);
    eff = (s > 5) ? 0 : s;
    for (int i = 0; i < 8; i++) slot[i] = $urandom;
    slot[eff] = sd;
    in_valid = v; sel = 3'(s); rd = 5'(r); rf_we = w;
    out_ready = ory; flush = fl; lu_valid = luv;
    rs2 = $urandom; imm = $urandom; alu_src = 1'($urandom_range(0, 1));
    #1;
    do_push = rst_n && v && (sb.size() < 2) && !fl && (s != 1 || luv);
    e.data = slot[eff];
    e.rd   = 5'(r);
    e.we   = w && (r != 0);
    #2;
    if (fl) sb.delete();
    else if (do_push) begin
      sb.push_back(e);
      if (s > 5) err_m = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b0;
    sb.delete();
    err_m = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_err", sel_err, 0);
    chk("async_rst_data", wb_data, 0);
    @(negedge clk);
    @(negedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) slot[i] = '0;
    @(negedge clk);
    @(negedge clk);
    #4;
    rst_n = 1'b1;

    // single push into an empty buffer, visible the next cycle
    step(1, 0, 5, 1, 1, 0, 0, 32'h11);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);

    // fill while stalled, then drain in order
    step(1, 4, 3, 1, 0, 0, 0, 32'hC5);
    step(1, 5, 4, 1, 0, 0, 0, 32'h104);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);

    // load-unit request waits for lu_valid
    for (int i = 0; i < 3; i++) step(1, 1, 6, 1, 0, 0, 0, 32'hABCD);
    step(1, 1, 6, 1, 0, 0, 1, 32'hABCD);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);

    // forwarding picks the younger of two matching entries
    fwd_a = 5'd7;
    step(1, 0, 7, 1, 0, 0, 0, 32'h1);
    step(1, 0, 7, 1, 0, 0, 0, 32'h2);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    fwd_a = 5'd0;
    step(1, 0, 0, 1, 0, 0, 0, 32'h33);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);

    // flush a full buffer with a concurrent request, then a bad select
    step(1, 0, 2, 1, 0, 0, 0, 32'h5);
    step(1, 2, 3, 1, 0, 0, 0, 32'h6);
    step(1, 3, 4, 1, 0, 1, 0, 32'h7);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 7, 9, 1, 1, 0, 0, 32'h5A5A);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);

    // reset with entries in flight
    step(1, 2, 10, 1, 0, 0, 0, 32'h77);
    step(1, 3, 11, 1, 0, 0, 0, 32'h88);
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      fwd_a = 5'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), $urandom);
      if (n == 200) do_reset();
    end
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
